// File: rtl/sprite_palette_arbiter_if.sv
// Handshake bundle between the two sprite fetchers, the shared palette lookup and the
// frame-buffer writer. The arbiter uses the slave modport; the environment uses master.
interface sprite_palette_arbiter_if #(
   parameter int unsigned TAG_W = 8
);
   logic             req0_valid;
   logic [3:0]       req0_index;
   logic [TAG_W-1:0] req0_tag;
   logic             req0_ready;
   logic             req1_valid;
   logic [3:0]       req1_index;
   logic [TAG_W-1:0] req1_tag;
   logic             req1_ready;
   logic [3:0]       pal_index;
   logic [3:0]       pal_red;
   logic [3:0]       pal_green;
   logic [3:0]       pal_blue;
   logic             out_valid;
   logic             out_ready;
   logic             out_src;
   logic [TAG_W-1:0] out_tag;
   logic [3:0]       out_red;
   logic [3:0]       out_green;
   logic [3:0]       out_blue;
   logic             out_transp;

   modport slave (
      input  req0_valid, req0_index, req0_tag,
      output req0_ready,
      input  req1_valid, req1_index, req1_tag,
      output req1_ready,
      output pal_index,
      input  pal_red, pal_green, pal_blue,
      output out_valid, out_src, out_tag, out_red, out_green, out_blue, out_transp,
      input  out_ready
   );

   modport master (
      output req0_valid, req0_index, req0_tag,
      input  req0_ready,
      output req1_valid, req1_index, req1_tag,
      input  req1_ready,
      input  pal_index,
      output pal_red, pal_green, pal_blue,
      input  out_valid, out_src, out_tag, out_red, out_green, out_blue, out_transp,
      output out_ready
   );
endinterface

// File: rtl/sprite_palette_arbiter.sv
// Two-requester burst arbiter over a shared combinational palette with a registered output stage.
// Define SPRITE_PAL_TRANSP_EN to flag TRANSP_IDX pixels as transparent and blank their RGB.
module sprite_palette_arbiter #(
   parameter int unsigned TAG_W      = 8,
   parameter int unsigned BURST      = 16,
   parameter int unsigned TRANSP_IDX = 15
) (
   input logic                     Clk,
   input logic                     Reset_n,
   sprite_palette_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = $clog2(BURST + 1);
   localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST);
   localparam logic [3:0]       TRANSP_C = 4'(TRANSP_IDX);
`ifdef SPRITE_PAL_TRANSP_EN
   localparam bit TRANSP_EN = 1'b1;
`else
   localparam bit TRANSP_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             rr_last_q, rr_last_d;

   logic             out_valid_q;
   logic             out_src_q;
   logic [TAG_W-1:0] out_tag_q;
   logic [11:0]      out_rgb_q;
   logic             out_transp_q;

   logic             gnt0, gnt1;
   logic             accept, xfer0, xfer1;
   logic [3:0]       sel_index;
   logic             is_transp;
   logic [11:0]      cap_rgb;

   // Burst limit only yields the grant when the other side is actually waiting.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.req0_valid && (!bus.req1_valid || rr_last_q)) gnt0 = 1'b1;
            else if (bus.req1_valid)                               gnt1 = 1'b1;
         end
         OWN0: begin
            if (bus.req0_valid && !(bus.req1_valid && beat_cnt_q == BURST_C)) gnt0 = 1'b1;
            else if (bus.req1_valid)                                           gnt1 = 1'b1;
         end
         OWN1: begin
            if (bus.req1_valid && !(bus.req0_valid && beat_cnt_q == BURST_C)) gnt1 = 1'b1;
            else if (bus.req0_valid)                                           gnt0 = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      accept    = !out_valid_q || bus.out_ready;
      xfer0     = Reset_n && accept && gnt0;
      xfer1     = Reset_n && accept && gnt1;
      sel_index = gnt1 ? bus.req1_index : bus.req0_index;
      is_transp = TRANSP_EN && (sel_index == TRANSP_C);
      cap_rgb   = is_transp ? '0 : {bus.pal_red, bus.pal_green, bus.pal_blue};
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      rr_last_d  = rr_last_q;
      if (xfer0) begin
         rr_last_d = 1'b0;
         if (state_q == OWN0) begin
            if (beat_cnt_q != BURST_C) beat_cnt_d = beat_cnt_q + 1'b1;
         end else begin
            state_d    = OWN0;
            beat_cnt_d = CNT_W'(1);
         end
      end else if (xfer1) begin
         rr_last_d = 1'b1;
         if (state_q == OWN1) begin
            if (beat_cnt_q != BURST_C) beat_cnt_d = beat_cnt_q + 1'b1;
         end else begin
            state_d    = OWN1;
            beat_cnt_d = CNT_W'(1);
         end
      end else if (accept && !bus.req0_valid && !bus.req1_valid) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         rr_last_q    <= 1'b1;
         out_valid_q  <= 1'b0;
         out_src_q    <= 1'b0;
         out_tag_q    <= '0;
         out_rgb_q    <= '0;
         out_transp_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         rr_last_q  <= rr_last_d;
         if (xfer0 || xfer1) begin
            out_valid_q  <= 1'b1;
            out_src_q    <= xfer1;
            out_tag_q    <= xfer1 ? bus.req1_tag : bus.req0_tag;
            out_rgb_q    <= cap_rgb;
            out_transp_q <= is_transp;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   always_comb begin
      bus.req0_ready = xfer0;
      bus.req1_ready = xfer1;
      bus.pal_index  = sel_index;
      bus.out_valid  = out_valid_q;
      bus.out_src    = out_src_q;
      bus.out_tag    = out_tag_q;
      bus.out_red    = out_rgb_q[11:8];
      bus.out_green  = out_rgb_q[7:4];
      bus.out_blue   = out_rgb_q[3:0];
      bus.out_transp = out_transp_q;
   end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter with a small combinational palette model.
module tb_sprite_palette_arbiter;

   logic        Clk     = 1'b0;
   logic        Reset_n = 1'b0;
   int unsigned pass_cnt  = 0;
   int unsigned total_cnt = 0;

   sprite_palette_arbiter_if #(.TAG_W(8)) bus ();

   sprite_palette_arbiter #(
      .TAG_W(8),
      .BURST(16),
      .TRANSP_IDX(15)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   function automatic logic [11:0] pal_lut(input logic [3:0] i);
      case (i)
         4'd1:    pal_lut = 12'hFEA;
         4'd2:    pal_lut = 12'h432;
         4'd3:    pal_lut = 12'hE74;
         4'd15:   pal_lut = 12'hF0F;
         default: pal_lut = {i, ~i, i ^ 4'h9};
      endcase
   endfunction

   assign {bus.pal_red, bus.pal_green, bus.pal_blue} = pal_lut(bus.pal_index);

   task automatic idle_inputs();
      bus.req0_valid = 1'b0; bus.req0_index = '0; bus.req0_tag = '0;
      bus.req1_valid = 1'b0; bus.req1_index = '0; bus.req1_tag = '0;
      bus.out_ready  = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_index = 4'd1; bus.req0_tag = 8'h11;
      bus.req1_valid = 1'b1; bus.req1_index = 4'd2; bus.req1_tag = 8'h22;
      bus.out_ready  = 1'b1;
      repeat (2) @(negedge Clk);
      #1;
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
      else pass_cnt++;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
         $display("FAIL reset_ready got=%b exp=00", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      total_cnt++;
      if ({bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue, bus.out_transp} !== 22'd0)
         $display("FAIL reset_outs got=%h exp=0",
                  {bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue, bus.out_transp});
      else pass_cnt++;
      Reset_n = 1'b1;
      #1;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
         $display("FAIL reset_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      total_cnt++;
      if (bus.pal_index !== 4'd1) $display("FAIL reset_pal_index got=%0d exp=1", bus.pal_index);
      else pass_cnt++;
      @(negedge Clk);
      total_cnt++;
      if ({bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue} !== {2'b10, 8'h11, 12'hFEA})
         $display("FAIL reset_first_out got=%h exp=%h",
                  {bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue},
                  {2'b10, 8'h11, 12'hFEA});
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_single();
      logic [11:0] exp_rgb [1:3];
      exp_rgb = '{12'hFEA, 12'h432, 12'hE74};
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         bus.req0_valid = 1'b1; bus.req0_index = 4'(i); bus.req0_tag = 8'(i);
         #1;
         total_cnt++;
         if (bus.req0_ready !== 1'b1) $display("FAIL single_ready%0d got=%b exp=1", i, bus.req0_ready);
         else pass_cnt++;
         @(negedge Clk);
         total_cnt++;
         if ({bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue} !== {2'b10, 8'(i), exp_rgb[i]})
            $display("FAIL single_out%0d got=%h exp=%h", i,
                     {bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue},
                     {2'b10, 8'(i), exp_rgb[i]});
         else pass_cnt++;
      end
      bus.req0_valid = 1'b0;
      @(negedge Clk);
      total_cnt++;
      if (bus.out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", bus.out_valid);
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_burst();
      logic owner;
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_index = 4'd2;
      for (int c = 0; c < 48; c++) begin
         owner = ((c / 16) % 2) == 1;
         #1;
         total_cnt++;
         if ({bus.req1_ready, bus.req0_ready} !== (owner ? 2'b10 : 2'b01))
            $display("FAIL burst_grant c=%0d got=%b exp=%b", c, {bus.req1_ready, bus.req0_ready},
                     owner ? 2'b10 : 2'b01);
         else pass_cnt++;
         @(negedge Clk);
         total_cnt++;
         if ({bus.out_valid, bus.out_src} !== {1'b1, owner})
            $display("FAIL burst_out c=%0d got=%b exp=%b", c, {bus.out_valid, bus.out_src}, {1'b1, owner});
         else pass_cnt++;
      end
      idle_inputs();
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd2; bus.req0_tag = 8'h55;
      @(negedge Clk);
      bus.out_ready = 1'b0; bus.req0_index = 4'd3; bus.req0_tag = 8'h66;
      for (int k = 0; k < 5; k++) begin
         #1;
         total_cnt++;
         if ({bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue} !== {2'b10, 8'h55, 12'h432})
            $display("FAIL bp_hold k=%0d got=%h exp=%h", k,
                     {bus.out_valid, bus.out_src, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue},
                     {2'b10, 8'h55, 12'h432});
         else pass_cnt++;
         total_cnt++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
            $display("FAIL bp_ready k=%0d got=%b exp=00", k, {bus.req1_ready, bus.req0_ready});
         else pass_cnt++;
         @(negedge Clk);
      end
      bus.out_ready = 1'b1;
      #1;
      total_cnt++;
      if (bus.req0_ready !== 1'b1) $display("FAIL bp_resume_ready got=%b exp=1", bus.req0_ready);
      else pass_cnt++;
      @(negedge Clk);
      total_cnt++;
      if ({bus.out_valid, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue} !== {1'b1, 8'h66, 12'hE74})
         $display("FAIL bp_resume_out got=%h exp=%h",
                  {bus.out_valid, bus.out_tag, bus.out_red, bus.out_green, bus.out_blue}, {1'b1, 8'h66, 12'hE74});
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_handover();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_index = 4'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         total_cnt++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
            $display("FAIL handover_own0 k=%0d got=%b exp=01", k, {bus.req1_ready, bus.req0_ready});
         else pass_cnt++;
         @(negedge Clk);
      end
      bus.req0_valid = 1'b0;
      #1;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
         $display("FAIL handover_switch got=%b exp=10", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      @(negedge Clk);
      bus.req0_valid = 1'b1;
      // req1 started its burst at one beat, so 15 more are due before req0 returns
      for (int k = 0; k < 15; k++) begin
         #1;
         total_cnt++;
         if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
            $display("FAIL handover_own1 k=%0d got=%b exp=10", k, {bus.req1_ready, bus.req0_ready});
         else pass_cnt++;
         @(negedge Clk);
      end
      #1;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
         $display("FAIL handover_limit got=%b exp=01", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      @(negedge Clk);
      idle_inputs();
   endtask

   task automatic test_rr_tie();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd1;
      @(negedge Clk);
      bus.req0_valid = 1'b0;
      @(negedge Clk);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req1_index = 4'd2;
      #1;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10)
         $display("FAIL rr_tie got=%b exp=10", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      @(negedge Clk);
      idle_inputs();
   endtask

   task automatic test_transp();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd15; bus.req0_tag = 8'hAB;
      #1;
      total_cnt++;
      if (bus.pal_index !== 4'd15) $display("FAIL transp_pal_index got=%0d exp=15", bus.pal_index);
      else pass_cnt++;
      @(negedge Clk);
      bus.req0_index = 4'd14; bus.req0_tag = 8'hAC;
      total_cnt++;
`ifdef SPRITE_PAL_TRANSP_EN
      if ({bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag} !== {1'b1, 12'h000, 8'hAB})
         $display("FAIL transp_key got=%h exp=%h",
                  {bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag}, {1'b1, 12'h000, 8'hAB});
      else pass_cnt++;
`else
      if ({bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag} !== {1'b0, 12'hF0F, 8'hAB})
         $display("FAIL transp_key got=%h exp=%h",
                  {bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag}, {1'b0, 12'hF0F, 8'hAB});
      else pass_cnt++;
`endif
      @(negedge Clk);
      total_cnt++;
      if ({bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag} !== {1'b0, 12'hE17, 8'hAC})
         $display("FAIL transp_plain got=%h exp=%h",
                  {bus.out_transp, bus.out_red, bus.out_green, bus.out_blue, bus.out_tag}, {1'b0, 12'hE17, 8'hAC});
      else pass_cnt++;
      idle_inputs();
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_index = 4'd1;
      bus.req1_valid = 1'b1; bus.req1_index = 4'd2;
      repeat (3) @(negedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      total_cnt++;
      if ({bus.out_valid, bus.req1_ready, bus.req0_ready} !== 3'b000)
         $display("FAIL midreset_clear got=%b exp=000", {bus.out_valid, bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      @(negedge Clk);
      Reset_n = 1'b1;
      #1;
      total_cnt++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
         $display("FAIL midreset_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready});
      else pass_cnt++;
      @(negedge Clk);
      total_cnt++;
      if ({bus.out_valid, bus.out_src} !== 2'b10)
         $display("FAIL midreset_out got=%b exp=10", {bus.out_valid, bus.out_src});
      else pass_cnt++;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single();
      test_burst();
      test_backpressure();
      test_handover();
      test_rr_tie();
      test_transp();
      test_mid_reset();
      repeat (2) @(negedge Clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
